// File: rtl/lcd_scanout_pkg.sv
// Shared constants, scan FSM state type and pixel helpers for lcd_scanout.
package lcd_scanout_pkg;

    localparam int LCD_WIDTH = 96;
    localparam int LCD_PAGES = 8;
    localparam int LCD_ROWS  = 64;
    localparam int FB_DEPTH  = 6144;
    localparam int FB_AW     = 13;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        EMIT    = 3'd3,
        DONE    = 3'd4
    } scan_state_t;

    // "On" intensity: 6-bit contrast stretched to 8 bits so 0 -> 0x00 and 0x3F -> 0xFF.
    function automatic logic [7:0] pixel_level(input logic [5:0] contrast);
        return {contrast, contrast[5:4]};
    endfunction

    // row * 96 as two shifts; row <= 63 keeps the result inside FB_AW bits.
    function automatic logic [FB_AW-1:0] row_base(input logic [6:0] row);
        logic [FB_AW-1:0] r;
        r = FB_AW'(row);
        return (r << 6) + (r << 5);
    endfunction

endpackage

// File: rtl/lcd_history_ram.sv
// 1-bit x 6144 previous-frame pixel store, one write port, one synchronous read port.
module lcd_history_ram
    import lcd_scanout_pkg::*;
(
    input  logic             clk,
    input  logic             ce,
    input  logic             we,
    input  logic [FB_AW-1:0] waddr,
    input  logic             wdata,
    input  logic [FB_AW-1:0] raddr,
    output logic             rdata
);

    logic mem [0:FB_DEPTH-1];

    // Write and registered read, both qualified by the clock enable.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lcd_scanout.sv
// Walks the LCD column RAM after each finished frame and streams 8-bit pixels
// into a 96x64 framebuffer over a ready/valid write port.
// Optional build macro LCD_SCANOUT_BLEND_EN: blends each pixel with the
// previous frame's pixel held in a 1-bit history RAM.
//
// state   | meaning
// IDLE    | waiting for frame_complete or a pending request
// FETCH   | column address (x,y) driven to the LCD controller
// CAPTURE | column byte latched, bit index cleared
// EMIT    | one pixel offered per bit, held until fb_ready
// DONE    | frame_done pulse, then idle or restart if pending
module lcd_scanout
    import lcd_scanout_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_ce,
    input  logic             frame_complete,
    input  logic [5:0]       lcd_contrast,
    output logic [7:0]       lcd_read_x,
    output logic [3:0]       lcd_read_y,
    input  logic [7:0]       lcd_read_column,
    output logic             fb_write,
    output logic [FB_AW-1:0] fb_address,
    output logic [7:0]       fb_data,
    input  logic             fb_ready,
    output logic             busy,
    output logic             frame_done
);

    scan_state_t      state, state_nxt;
    logic [7:0]       x;
    logic [3:0]       y;
    logic [2:0]       b;
    logic [7:0]       column;
    logic             pending;
    logic             accept, last_bit, last_col, last_page, trigger;
    logic             pix_cur;
    logic [7:0]       on_level, pix_level;
    logic [FB_AW-1:0] pix_addr;

    assign accept    = (state == EMIT) && fb_ready;
    assign last_bit  = (b == 3'd7);
    assign last_col  = (x == 8'(LCD_WIDTH - 1));
    assign last_page = (y == 4'(LCD_PAGES - 1));
    assign trigger   = frame_complete || pending;
    assign on_level  = pixel_level(lcd_contrast);
    assign pix_cur   = column[b];
    assign pix_addr  = row_base({y[2:0], b}) + FB_AW'(x);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = FETCH;
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = EMIT;
            EMIT: begin
                if (accept && last_bit) begin
                    state_nxt = (last_col && last_page) ? DONE : FETCH;
                end
            end
            DONE:    state_nxt = trigger ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk_ce) begin
            state <= state_nxt;
        end
    end

    // Column/page/bit walk; x and y fall back to 0 after the last column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            b      <= '0;
            column <= '0;
        end else if (clk_ce) begin
            if (state == CAPTURE) begin
                column <= lcd_read_column;
                b      <= '0;
            end else if (accept) begin
                b <= b + 3'd1;
                if (last_bit) begin
                    if (last_col) begin
                        x <= '0;
                        y <= last_page ? 4'd0 : y + 4'd1;
                    end else begin
                        x <= x + 8'd1;
                    end
                end
            end
        end
    end

    // Single-deep request latch; consumed whenever a new frame starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (clk_ce) begin
            if ((state == IDLE || state == DONE) && trigger) begin
                pending <= 1'b0;
            end else if (frame_complete) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef LCD_SCANOUT_BLEND_EN
    logic             first_frame;
    logic             hist_q;
    logic             pix_prev;
    logic [2:0]       b_rd;
    logic [FB_AW-1:0] hist_raddr;

    // Read address tracks the bit that EMIT will show next edge, so data is ready with no extra cycle.
    always_comb begin
        b_rd = b;
        if (state == CAPTURE) begin
            b_rd = 3'd0;
        end else if (accept) begin
            b_rd = b + 3'd1;
        end
    end

    assign hist_raddr = row_base({y[2:0], b_rd}) + FB_AW'(x);

    lcd_history_ram u_history (
        .clk   (clk),
        .ce    (clk_ce),
        .we    (accept),
        .waddr (pix_addr),
        .wdata (pix_cur),
        .raddr (hist_raddr),
        .rdata (hist_q)
    );

    // History content is undefined until one full frame has been written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_frame <= 1'b1;
        end else if (clk_ce && state == DONE) begin
            first_frame <= 1'b0;
        end
    end

    assign pix_prev = first_frame ? pix_cur : hist_q;

    // Both on: full level; exactly one on: half level; none: black.
    always_comb begin
        pix_level = 8'h00;
        if (pix_cur && pix_prev) begin
            pix_level = on_level;
        end else if (pix_cur ^ pix_prev) begin
            pix_level = on_level >> 1;
        end
    end
`else
    assign pix_level = pix_cur ? on_level : 8'h00;
`endif

    assign fb_write   = (state == EMIT);
    assign fb_address = fb_write ? pix_addr : '0;
    assign fb_data    = fb_write ? pix_level : 8'h00;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign lcd_read_x = x;
    assign lcd_read_y = y;

endmodule
